// File: rtl/pll_sim_pkg.sv
// Shared types and frequency helpers for the multi-output PLL simulation model.
`timescale 1ps/1ps
package pll_sim_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        MEASURE = 2'd1,
        SETTLE  = 2'd2,
        LOCKED  = 2'd3
    } pll_state_t;

    localparam int unsigned VCO_MIN_MHZ = 533;
    localparam int unsigned VCO_MAX_MHZ = 1066;
    localparam int unsigned CNT_W       = 16;

    // Half period (ps) of one output channel: ref * (R+1) * 2^Q * (O+1) / (F+1) / 2.
    function automatic realtime out_half_period(
        input logic [31:0] ref_ps,
        input int unsigned divr,
        input int unsigned divf,
        input int unsigned divq,
        input int unsigned odiv
    );
        realtime period;
        period = real'(ref_ps) * real'(divr + 32'd1) * real'(32'd1 << divq)
               * real'(odiv + 32'd1) / real'(divf + 32'd1);
        return period / 2.0;
    endfunction

    function automatic real vco_mhz(
        input realtime     ref_ps,
        input int unsigned divr,
        input int unsigned divf
    );
        if (ref_ps <= 0.0) return 0.0;
        return (1.0e6 / ref_ps) * real'(divf + 32'd1) / real'(divr + 32'd1);
    endfunction

    // True when a fresh reference measurement is off by more than 1/16 of the stored one.
    function automatic logic period_deviates(
        input realtime     meas_ps,
        input logic [31:0] ref_ps
    );
        realtime diff;
        diff = meas_ps - real'(ref_ps);
        if (diff < 0.0) diff = -diff;
        return (diff * 16.0) > real'(ref_ps);
    endfunction

endpackage

// File: rtl/pll_sim_clk_gen.sv
// One behavioural output clock: starts low, toggles every half_period while enabled.
`timescale 1ps/1ps
module pll_sim_clk_gen (
    input  logic enable,
    input  real  half_period,
    output logic clock
);

    logic r_clk;

    // A disabled channel parks low and restarts a full half period after enable rises.
    always begin : toggle_proc
        r_clk = 1'b0;
        wait (enable);
        while (enable) begin
            #(half_period < 1.0 ? 1.0 : half_period);
            if (enable) r_clk = ~r_clk;
        end
    end

    assign clock = r_clk & enable;

endmodule

// File: rtl/pll_multi_sim_model.sv
// Behavioural iCE40-style PLL with NUM_OUT post-divided clocks and realistic lock timing.
// PLL_MULTI_SIM_MODEL_FREQ_MONITOR_EN: re-measure the reference while locked and re-acquire on drift.
`timescale 1ps/1ps
module pll_multi_sim_model
    import pll_sim_pkg::*;
#(
    parameter int unsigned NUM_OUT         = 2,
    parameter int unsigned DIVR            = 0,
    parameter int unsigned DIVF            = 71,
    parameter int unsigned DIVQ            = 3,
    parameter logic [15:0] OUT_DIV         = 16'h0000,
    parameter int unsigned LOCK_CYCLES     = 64,
    parameter bit          GATE_UNTIL_LOCK = 1'b1
) (
    input  logic               clk,
    input  logic               sresetn,
    input  logic               bypass,
    output logic [NUM_OUT-1:0] pll_clk,
    output logic               lock,
    output logic [31:0]        ref_period_ps
);

    pll_state_t       r_state;
    pll_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lock_nxt;
    logic             w_load_period;
    logic             w_gen_en;
    realtime          r_last_edge;

    initial begin : param_check
        if (DIVQ < 1 || DIVQ > 6)
            $error("pll_multi_sim_model: DIVQ=%0d outside 1..6", DIVQ);
        if (NUM_OUT < 1 || NUM_OUT > 4)
            $error("pll_multi_sim_model: NUM_OUT=%0d outside 1..4", NUM_OUT);
    end

    // Timestamps and the measured period live here because they need the time of this edge.
    always_ff @(posedge clk) begin : state_reg
        if (!sresetn) begin
            r_state       <= RESET;
            r_cnt         <= '0;
            lock          <= 1'b0;
            ref_period_ps <= '0;
            r_last_edge   <= 0.0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            lock        <= w_lock_nxt;
            r_last_edge <= $realtime;
            if (w_load_period) begin
                ref_period_ps <= 32'($rtoi($realtime - r_last_edge));
                if (vco_mhz($realtime - r_last_edge, DIVR, DIVF) < real'(VCO_MIN_MHZ) ||
                    vco_mhz($realtime - r_last_edge, DIVR, DIVF) > real'(VCO_MAX_MHZ))
                    $warning("pll_multi_sim_model: VCO %f MHz outside %0d..%0d MHz",
                             vco_mhz($realtime - r_last_edge, DIVR, DIVF),
                             VCO_MIN_MHZ, VCO_MAX_MHZ);
            end
`ifdef PLL_MULTI_SIM_MODEL_FREQ_MONITOR_EN
            if (r_state == LOCKED &&
                period_deviates($realtime - r_last_edge, ref_period_ps)) begin
                r_state <= MEASURE;
                lock    <= 1'b0;
            end
`endif
        end
    end

    always_comb begin : fsm_next
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_lock_nxt    = 1'b0;
        w_load_period = 1'b0;
        case (r_state)
            RESET: begin
                w_state_nxt = MEASURE;
            end
            MEASURE: begin
                w_load_period = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = SETTLE;
            end
            SETTLE: begin
                if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                    w_state_nxt = LOCKED;
                    w_lock_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            LOCKED: begin
                w_lock_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = RESET;
            end
        endcase
    end

    assign w_gen_en = GATE_UNTIL_LOCK ? lock
                                      : (r_state == SETTLE || r_state == LOCKED);

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        real  w_half;
        logic w_gen_clk;
        logic r_hold;

        always_comb w_half = out_half_period(ref_period_ps, DIVR, DIVF, DIVQ,
                                             32'(OUT_DIV[4*k +: 4]));

        pll_sim_clk_gen u_clk_gen (
            .enable      (w_gen_en),
            .half_period (w_half),
            .clock       (w_gen_clk)
        );

        // After bypass drops, hold low until the generator's next rising edge so no runt appears.
        always begin : bypass_resync
            r_hold = 1'b0;
            @(negedge bypass);
            r_hold = 1'b1;
            @(posedge w_gen_clk or posedge bypass);
        end

        assign pll_clk[k] = bypass ? clk : (w_gen_clk & ~r_hold);
    end

endmodule

// File: tb/tb_pll_multi_sim_model.sv
// Directed bench for pll_multi_sim_model: lock timing, output periods, reset, bypass, gating, VCO range.
`timescale 1ps/1ps
module tb_pll_multi_sim_model;

    int n_checks = 0;
    int n_pass   = 0;

    logic        clk_a = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        byp_a = 1'b0;
    logic        byp_0 = 1'b0;
    logic [1:0]  pll_a;
    logic        lock_a;
    logic [31:0] ref_a;
    logic [0:0]  pll_b;
    logic        lock_b;
    logic [31:0] ref_b;
    logic [0:0]  pll_c;
    logic        lock_c;
    logic [31:0] ref_c;
    int          probe_sel = 0;
    logic        probe;

    // 12 MHz reference: 83333 ps period.
    always begin
        clk_a = 1'b1; #41667;
        clk_a = 1'b0; #41666;
    end

    pll_multi_sim_model #(
        .NUM_OUT(2), .DIVR(0), .DIVF(71), .DIVQ(3), .OUT_DIV(16'h0010),
        .LOCK_CYCLES(64), .GATE_UNTIL_LOCK(1'b1)
    ) u_dut_a (
        .clk(clk_a), .sresetn(rst_a), .bypass(byp_a),
        .pll_clk(pll_a), .lock(lock_a), .ref_period_ps(ref_a)
    );

    pll_multi_sim_model #(
        .NUM_OUT(1), .DIVR(0), .DIVF(71), .DIVQ(3), .OUT_DIV(16'h0000),
        .LOCK_CYCLES(10), .GATE_UNTIL_LOCK(1'b0)
    ) u_dut_b (
        .clk(clk_a), .sresetn(rst_b), .bypass(byp_0),
        .pll_clk(pll_b), .lock(lock_b), .ref_period_ps(ref_b)
    );

    pll_multi_sim_model #(
        .NUM_OUT(1), .DIVR(0), .DIVF(127), .DIVQ(1), .OUT_DIV(16'h0000),
        .LOCK_CYCLES(64), .GATE_UNTIL_LOCK(1'b1)
    ) u_dut_c (
        .clk(clk_a), .sresetn(rst_b), .bypass(byp_0),
        .pll_clk(pll_c), .lock(lock_c), .ref_period_ps(ref_c)
    );

`ifdef PLL_MULTI_SIM_MODEL_FREQ_MONITOR_EN
    logic        clk_m = 1'b0;
    logic        rst_m = 1'b0;
    int          m_per = 83333;
    logic [0:0]  pll_m;
    logic        lock_m;
    logic [31:0] ref_m;

    // Period is sampled at each rising edge so a change lands on a whole cycle.
    always begin : clk_m_gen
        int cur;
        cur = m_per;
        clk_m = 1'b1; #(cur - cur / 2);
        clk_m = 1'b0; #(cur / 2);
    end

    pll_multi_sim_model #(
        .NUM_OUT(1), .DIVR(0), .DIVF(71), .DIVQ(3), .OUT_DIV(16'h0000),
        .LOCK_CYCLES(8), .GATE_UNTIL_LOCK(1'b1)
    ) u_dut_m (
        .clk(clk_m), .sresetn(rst_m), .bypass(byp_0),
        .pll_clk(pll_m), .lock(lock_m), .ref_period_ps(ref_m)
    );
`endif

    always_comb begin
        case (probe_sel)
            0:       probe = pll_a[0];
            1:       probe = pll_a[1];
            2:       probe = pll_b[0];
            3:       probe = pll_c[0];
`ifdef PLL_MULTI_SIM_MODEL_FREQ_MONITOR_EN
            4:       probe = pll_m[0];
`endif
            default: probe = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        n_checks++;
        diff = (got > exp) ? got - exp : exp - got;
        if (diff <= tol) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    endtask

    task automatic edges_a(input int n);
        repeat (n) @(posedge clk_a);
        #1;
    endtask

    // Rising-to-rising period of the probed clock; -1 if two edges never arrive.
    task automatic meas_period(input int sel, output longint per);
        logic   prev;
        longint t1;
        int     n_rise;
        probe_sel = sel;
        #1;
        prev   = probe;
        per    = -1;
        t1     = 0;
        n_rise = 0;
        for (int i = 0; i < 200000; i++) begin
            #1;
            if (probe && !prev) begin
                if (n_rise == 0) t1 = $time;
                else begin
                    per = $time - t1;
                    break;
                end
                n_rise++;
            end
            prev = probe;
        end
    endtask

    // Shortest complete high pulse of the probed clock inside a time window.
    task automatic min_high(input int sel, input int window, output longint min_w, output int n_pulses);
        logic   prev;
        longint t_rise;
        bit     seen_rise;
        probe_sel = sel;
        #1;
        prev      = probe;
        min_w     = 64'd1_000_000;
        n_pulses  = 0;
        seen_rise = 1'b0;
        t_rise    = 0;
        for (int i = 0; i < window; i++) begin
            #1;
            if (probe && !prev) begin
                t_rise    = $time;
                seen_rise = 1'b1;
            end else if (!probe && prev && seen_rise) begin
                if ($time - t_rise < min_w) min_w = $time - t_rise;
                n_pulses++;
            end
            prev = probe;
        end
    endtask

    initial begin : stim
        longint per;
        longint min_w;
        int     n_pulses;
        int     bad;

        // Reset state
        repeat (3) @(posedge clk_a);
        #1;
        chk("reset_lock", lock_a, 0, 0);
        chk("reset_ref_period", ref_a, 0, 0);
        chk("reset_pll_clk", pll_a, 0, 0);

        // Lock sequence and output frequencies
        @(negedge clk_a);
        rst_a = 1'b1;
        edges_a(2);
        chk("measured_ref_period", ref_a, 83333, 0);
        chk("lock_low_edge2", lock_a, 0, 0);
        edges_a(63);
        chk("lock_low_edge65", lock_a, 0, 0);
        chk("pll_gated_before_lock", pll_a, 0, 0);
        edges_a(1);
        chk("lock_high_edge66", lock_a, 1, 0);
        meas_period(0, per);
        chk("ch0_period_108mhz", per, 9259, 1);
        meas_period(1, per);
        chk("ch1_period_54mhz", per, 18518, 2);

        // Reset mid-lock
        @(negedge clk_a);
        #7000;
        rst_a = 1'b0;
        @(posedge clk_a);
        #1;
        chk("midreset_lock", lock_a, 0, 0);
        chk("midreset_pll_clk", pll_a, 0, 0);
        chk("midreset_ref_period", ref_a, 0, 0);
        repeat (2) @(posedge clk_a);
        @(negedge clk_a);
        rst_a = 1'b1;
        edges_a(65);
        chk("relock_low_edge65", lock_a, 0, 0);
        edges_a(1);
        chk("relock_high_edge66", lock_a, 1, 0);

        // Bypass follows the reference bit-for-bit
        @(negedge clk_a);
        #3000;
        byp_a = 1'b1;
        bad   = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_a);
            #1;
            if (pll_a != {2{clk_a}} || pll_a != 2'b11) bad++;
            @(negedge clk_a);
            #1;
            if (pll_a != {2{clk_a}} || pll_a != 2'b00) bad++;
        end
        chk("bypass_follow_mismatches", bad, 0, 0);
        chk("bypass_lock_kept", lock_a, 1, 0);
        @(negedge clk_a);
        #1000;
        byp_a = 1'b0;
        min_high(0, 60000, min_w, n_pulses);
        chk("bypass_exit_min_pulse", min_w, 4630, 1);
        chk("bypass_exit_resumes", (n_pulses >= 3) ? 1 : 0, 1, 0);

        // Ungated outputs (B) and out-of-range VCO (C)
        @(negedge clk_a);
        rst_b = 1'b1;
        edges_a(1);
        chk("ungated_edge1_pll", pll_b, 0, 0);
        edges_a(1);
        chk("ungated_edge2_pll_low", pll_b, 0, 0);
        #6000;
        chk("ungated_toggles_after_edge2", pll_b, 1, 0);
        chk("ungated_lock_low", lock_b, 0, 0);
        edges_a(9);
        chk("ungated_lock_low_edge11", lock_b, 0, 0);
        edges_a(1);
        chk("ungated_lock_high_edge12", lock_b, 1, 0);
        edges_a(54);
        chk("vco_hi_lock_edge66", lock_c, 1, 0);
        chk("vco_hi_ref_period", ref_c, 83333, 0);
        meas_period(3, per);
        chk("vco_hi_period", per, 1302, 1);

`ifdef PLL_MULTI_SIM_MODEL_FREQ_MONITOR_EN
        // Reference changes to 10 MHz while locked
        @(negedge clk_m);
        rst_m = 1'b1;
        for (int i = 0; i < 30 && !lock_m; i++) begin
            @(posedge clk_m);
            #1;
        end
        chk("mon_initial_lock", lock_m, 1, 0);
        @(negedge clk_m);
        m_per = 100000;
        @(posedge clk_m);
        #1;
        chk("mon_lock_before_slow_edge", lock_m, 1, 0);
        @(posedge clk_m);
        #1;
        chk("mon_lock_drop", lock_m, 0, 0);
        for (int i = 0; i < 30 && !lock_m; i++) begin
            @(posedge clk_m);
            #1;
        end
        chk("mon_relock", lock_m, 1, 0);
        chk("mon_ref_period", ref_m, 100000, 0);
        meas_period(4, per);
        chk("mon_period_90mhz", per, 11111, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_multi_sim_model.md
Name: pll_multi_sim_model

Overview:
- Clocked, parametrised behavioural simulation model of an iCE40-style PLL, for simulation builds only (not synthesised).
- Derives output frequency from the measured reference period and the DIVR/DIVF/DIVQ settings.
- Drives NUM_OUT output clocks, each with its own post-divider, plus a lock flag that follows a real acquire/settle/lock sequence.
- Stands in for the vendor primitive in top-level benches wherever the design needs more than one derived clock or realistic lock timing.

Parameters:
- NUM_OUT, 2, number of output clocks (1..4).
- DIVR, 0, reference divider; divides by DIVR+1 (0..15).
- DIVF, 71, feedback divider; multiplies by DIVF+1 (0..127).
- DIVQ, 3, VCO output divider; divides by 2**DIVQ (1..6).
- OUT_DIV, 16'h0000, packed 4-bit field per channel k at [4k+3:4k]; channel k divides by OUT_DIV[k]+1.
- LOCK_CYCLES, 64, reference cycles spent in SETTLE before lock asserts (1..65535).
- GATE_UNTIL_LOCK, 1, when 1, outputs are held low while lock=0.

Ports:
- clk, input, 1, reference clock; all state updates on posedge.
- sresetn, input, 1, synchronous active-low reset.
- bypass, input, 1, 1 = every pll_clk output follows clk directly.
- pll_clk, output, NUM_OUT, generated clocks.
- lock, output, 1, PLL locked.
- ref_period_ps, output, 32, last measured reference period in ps (integer, truncated).

Behaviour:
- Reset: sampled on posedge clk.
  - While sresetn=0: lock=0, ref_period_ps=0, state=RESET, pll_clk all 0 (unless bypass=1).
  - Reset asserted mid-lock drops lock on that same edge.
- State machine, advancing on posedge clk when sresetn=1:
  - RESET: go to MEASURE; store edge timestamp.
  - MEASURE: on the next edge, compute period = now - last edge, load ref_period_ps, go to SETTLE, clear settle counter.
  - SETTLE: increment counter every edge; on the edge where counter reaches LOCK_CYCLES-1, go to LOCKED.
  - LOCKED: lock=1.
- Lock latency: lock rises on the (LOCK_CYCLES+2)th posedge after reset release.
- Frequency rules:
  - f_vco = f_ref*(DIVF+1)/(DIVR+1).
  - f_q = f_vco/2**DIVQ.
  - channel k: f_q/(OUT_DIV[k]+1).
  - Half-period is computed in realtime (ps resolution) from ref_period_ps.
  - Each channel runs its own toggle process; it starts low and first rises half a period after entering LOCKED.
  - With GATE_UNTIL_LOCK=0, toggling starts on entry to SETTLE.
- Parameter checks at time 0 ($error, simulation continues):
  - DIVQ outside 1..6.
  - NUM_OUT outside 1..4.
- VCO range check: after measurement, $warning if f_vco is outside 533..1066 MHz.
- Bypass:
  - bypass=1 combinationally routes clk to every pll_clk bit.
  - The state machine keeps running, so lock behaviour is unchanged.
  - Deasserting bypass resumes generated clocks at the next half-period boundary without a glitch shorter than one half-period.
- Reference stopped: outputs keep toggling at the last rate; lock stays 1. Stop detection exists only with the optional feature.

Optional Feature:
- Macro: PLL_MULTI_SIM_MODEL_FREQ_MONITOR_EN.
- Defined:
  - In LOCKED, every edge re-measures the reference period.
  - If it deviates from ref_period_ps by more than 1/16, lock drops on that edge, outputs gate per GATE_UNTIL_LOCK, and state returns to MEASURE (re-acquire, then LOCKED again after LOCK_CYCLES).
- Undefined: period is measured once per reset only.

Decomposition:
- Package pll_sim_pkg:
  - state enum {RESET, MEASURE, SETTLE, LOCKED}.
  - VCO_MIN_MHZ=533, VCO_MAX_MHZ=1066.
  - Function out_half_period(ref_ps, divr, divf, divq, odiv) returning realtime.
- Sub-module pll_sim_clk_gen: one instance per channel; inputs enable and half_period; output clock. Generate loop over NUM_OUT.

Test Plan:
1. Lock and frequencies: 12 MHz ref (83333 ps), DIVR=0, DIVF=71, DIVQ=3, OUT_DIV=16'h0010 -> ref_period_ps=83333; lock rises on the 66th edge after reset release; pll_clk[0] period 9259±1 ps (108 MHz); pll_clk[1] period 18518±2 ps (54 MHz).
2. Reset mid-lock: pull sresetn low for 3 cycles after lock -> lock=0 and pll_clk=0 on the first low edge; re-lock 66 edges after release.
3. Bypass: assert bypass with lock=1 -> pll_clk equals clk bit-for-bit; deassert -> no pulse shorter than 4629 ps.
4. Gating: GATE_UNTIL_LOCK=0, LOCK_CYCLES=10 -> pll_clk toggles from the 2nd edge while lock=0; lock rises on the 12th edge.
5. Freq monitor (macro defined): switch ref to 10 MHz after lock -> lock drops on the first 100000 ps edge; re-locks with ref_period_ps=100000 and pll_clk[0] period 11111±1 ps.
6. Range check: DIVF=127, DIVQ=1 with 12 MHz ref (VCO 1536 MHz) -> exactly one $warning; outputs still generated.
